// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 interrupt unit: register numbers,
// decoder Int_ctrl bit positions and the interrupt FSM state encoding.
package cp0_pkg;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int INT_ERET = 4;
    localparam int INT_CLI  = 3;
    localparam int INT_STI  = 2;
    localparam int INT_MTC  = 1;
    localparam int INT_MFC  = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } int_state_e;

endpackage

// File: rtl/cp0_int_unit_if.sv
// Decoder/CP0 access bus plus the request/ack handshake with the PC-select logic.
interface cp0_int_unit_if;

    logic [4:0]  Int_ctrl;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] pc_next;
    logic        int_ack;
    logic        int_req;
    logic [31:0] int_vector;
    logic [31:0] epc;
    logic        int_busy;

    modport master (
        output Int_ctrl, cp0_addr, cp0_wdata, pc_next, int_ack,
        input  cp0_rdata, int_req, int_vector, epc, int_busy
    );

    modport slave (
        input  Int_ctrl, cp0_addr, cp0_wdata, pc_next, int_ack,
        output cp0_rdata, int_req, int_vector, epc, int_busy
    );

endinterface

// File: rtl/cp0_int_unit_irq_edge_sync.sv
// One interrupt line: two-flop synchroniser followed by a one-cycle rising-edge pulse.
module irq_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/cp0_int_unit.sv
// Coprocessor-0 interrupt unit: IRQ edge latching, fixed-priority selection,
// request/ack handshake with the PC logic, EPC save and mfc0/mtc0 registers.
module cp0_int_unit
    import cp0_pkg::*;
#(
    parameter int          N_IRQ      = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0040
) (
    input  logic             clk,
    input  logic             rst,
    cp0_int_unit_if.slave    bus,
    input  logic [N_IRQ-1:0] irq,
    output logic [N_IRQ-1:0] pending
);

    localparam int SEL_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    int_state_e       state_q, state_d;
    logic             ie_q, ie_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [31:0]      epc_q, epc_d;

    logic [N_IRQ-1:0] irq_rise;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] clr_mask;
    logic [SEL_W-1:0] sel;
    logic             take_ack;
    logic             op_eret, op_cli, op_sti, op_mtc;
    logic [31:0]      status_word;
    logic [31:0]      cause_word;

    for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
        irq_edge_sync u_sync (
            .clk      (clk),
            .rst      (rst),
            .async_in (irq[i]),
            .rise_o   (irq_rise[i])
        );
    end

    assign op_eret  = bus.Int_ctrl[INT_ERET];
    assign op_cli   = bus.Int_ctrl[INT_CLI];
    assign op_sti   = bus.Int_ctrl[INT_STI];
    assign op_mtc   = bus.Int_ctrl[INT_MTC];
    assign eligible = pending_q & mask_q & {N_IRQ{ie_q}};

    // Scan from the top down so the lowest eligible index is the last to write sel.
    always_comb begin
        // NOTE: default first so every path assigns sel and no latch is inferred.
        sel = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) sel = SEL_W'(i);
        end
    end

    assign bus.int_vector = VEC_BASE + 32'(sel) * VEC_STRIDE;

    always_comb begin
        state_d      = state_q;
        bus.int_req  = 1'b0;
        bus.int_busy = 1'b0;
        take_ack     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|eligible) state_d = ST_REQ;
            end
            ST_REQ: begin
                // Withdraw at once when nothing is eligible so a late ack cannot service a dead request.
                bus.int_req = |eligible;
                if (~|eligible) begin
                    state_d = ST_IDLE;
                end else if (bus.int_ack) begin
                    take_ack = 1'b1;
                    state_d  = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                bus.int_busy = 1'b1;
                if (op_eret) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ie_d     = ie_q;
        mask_d   = mask_q;
        epc_d    = epc_q;
        clr_mask = '0;
        if (op_mtc && bus.cp0_addr == CP0_STATUS) begin
            ie_d   = bus.cp0_wdata[0];
            mask_d = bus.cp0_wdata[8 +: N_IRQ];
        end
        if (op_mtc && bus.cp0_addr == CP0_EPC) epc_d = bus.cp0_wdata;
        if (op_eret) ie_d = 1'b1;
        if (op_sti)  ie_d = 1'b1;
        if (op_cli)  ie_d = 1'b0;
        // The ack capture overrides any same-cycle software write to IE or EPC.
        if (take_ack) begin
            ie_d          = 1'b0;
            epc_d         = bus.pc_next;
            clr_mask[sel] = 1'b1;
        end
        pending_d = (pending_q & ~clr_mask) | irq_rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ie_q      <= 1'b0;
            mask_q    <= '1;
            pending_q <= '0;
            epc_q     <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q   <= state_d;
            ie_q      <= ie_d;
            mask_q    <= mask_d;
            pending_q <= pending_d;
            epc_q     <= epc_d;
        end
    end

    always_comb begin
        status_word              = '0;
        status_word[0]           = ie_q;
        status_word[8 +: N_IRQ]  = mask_q;
        cause_word               = '0;
        cause_word[8 +: N_IRQ]   = pending_q;
        unique case (bus.cp0_addr)
            CP0_STATUS: bus.cp0_rdata = status_word;
            CP0_CAUSE:  bus.cp0_rdata = cause_word;
            CP0_EPC:    bus.cp0_rdata = epc_q;
            default:    bus.cp0_rdata = '0;
        endcase
    end

    assign bus.epc = epc_q;
    assign pending = pending_q;

endmodule
